// File: rtl/dram_refresh_sched.sv
// DDR4 all-bank refresh scheduler: counts tREFI, accumulates owed refreshes,
// drains the command engine and holds traffic off for tRFC after each REFRESH.
module dram_refresh_sched #(
  parameter int T_REFI       = 6240,
  parameter int T_RFC        = 280,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_W        = 13
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       init_done,
  input  logic       req_valid,
  input  logic       cmd_busy,
  input  logic       ref_ack,
  output logic       req_grant,
  output logic       REFRESH,
  output logic [3:0] ref_pending,
  output logic       ref_urgent,
  output logic       ref_overflow,
  output logic       ref_active
);

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, RFC} state_t;

  localparam logic [CNT_W-1:0] REFI_LOAD = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD  = CNT_W'(T_RFC - 1);
  localparam logic [3:0]       MAX_P     = 4'(MAX_POSTPONE);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] int_cnt;
  logic [CNT_W-1:0] rfc_cnt;
  logic             tick;
  logic             ack_ok;
  logic             want_ref;
  logic             rfc_done;

  // Handshake: REFRESH is a level held from ISSUE entry until the edge that
  // samples ref_ack; acks seen in any other state carry no meaning.
  assign tick       = init_done && (int_cnt == '0);
  assign ack_ok     = (state == ISSUE) && ref_ack;
  assign ref_urgent = (ref_pending >= MAX_P);
  assign want_ref   = (ref_pending != 4'd0) && (!req_valid || ref_urgent);
  assign rfc_done   = (rfc_cnt == '0);
  assign req_grant  = init_done && (state == IDLE) && !ref_urgent && !RST;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (want_ref) state_nxt = DRAIN;
      DRAIN:   if (!cmd_busy) state_nxt = ISSUE;
      ISSUE:   if (ref_ack) state_nxt = RFC;
      RFC:     if (rfc_done) state_nxt = want_ref ? DRAIN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      int_cnt      <= REFI_LOAD;
      rfc_cnt      <= '0;
      ref_pending  <= 4'd0;
      ref_overflow <= 1'b0;
      REFRESH      <= 1'b0;
      ref_active   <= 1'b0;
    end else begin
      state      <= state_nxt;
      REFRESH    <= (state_nxt == ISSUE);
      ref_active <= (state_nxt == ISSUE) || (state_nxt == RFC);

      if (!init_done || int_cnt == '0) int_cnt <= REFI_LOAD;
      else                             int_cnt <= int_cnt - 1'b1;

      if (ack_ok)                       rfc_cnt <= RFC_LOAD;
      else if (state == RFC && !rfc_done) rfc_cnt <= rfc_cnt - 1'b1;

      // A tick and an accepted ack in the same cycle cancel out.
      if (tick && !ack_ok) begin
        if (ref_pending == MAX_P) ref_overflow <= 1'b1;
        else                      ref_pending  <= ref_pending + 4'd1;
      end else if (ack_ok && !tick && ref_pending != 4'd0) begin
        ref_pending <= ref_pending - 4'd1;
      end
    end
  end

endmodule
